// File: rtl/fetch_queue_pkg.sv
// Shared core typedefs for the fetch/decode boundary: word aliases, the
// fetch packet layout and the default queue depth.
package fetch_queue_pkg;

  typedef logic [15:0] w16;
  typedef logic [31:0] w32;

  typedef struct packed {
    w32   instr;
    w16   pc;
    logic approx;
  } fetch_packet_t;

  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

endpackage

// File: rtl/fetch_queue_ram.sv
// Packet storage for fetch_queue: synchronous write, asynchronous read, no reset.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  fetch_packet_t            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output fetch_packet_t            o_rdata
);

  fetch_packet_t r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with mispredict flush.
// Optional zero-latency empty-queue bypass: `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_en,
  input  logic [31:0]                in_instr,
  input  logic [15:0]                in_pc,
  input  logic                       in_approx,
  output logic                       in_reject,
  output logic                       out_en,
  output logic [31:0]                out_instr,
  output logic [15:0]                out_pc,
  output logic                       out_approx,
  input  logic                       out_reject,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  fetch_packet_t w_in_pkt;
  fetch_packet_t w_head_pkt;
  fetch_packet_t w_out_pkt;
  logic          w_queue_en;
  logic          w_bypass;
  logic          w_push;
  logic          w_write;
  logic          w_pop;

  assign w_in_pkt = '{instr: in_instr, pc: in_pc, approx: in_approx};

  // in_reject looks only at registered state, flush and reset: no decode->fetch comb path.
  assign in_reject  = (r_count == CNT_FULL) | flush | reset;
  assign w_queue_en = (r_count != '0) & ~flush & ~reset;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = (r_count == '0) & in_en & ~out_reject & ~flush & ~reset;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed packet is consumed straight from in_*, so it is neither stored nor popped.
  assign w_push  = in_en & ~in_reject;
  assign w_write = w_push & ~w_bypass;
  assign w_pop   = w_queue_en & ~out_reject;

  assign w_out_pkt  = w_bypass ? w_in_pkt : w_head_pkt;
  assign out_en     = w_queue_en | w_bypass;
  assign out_instr  = w_out_pkt.instr;
  assign out_pc     = w_out_pkt.pc;
  assign out_approx = w_out_pkt.approx;
  assign count      = r_count;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)   r_head <= r_head + PTR_W'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clock   (clock),
    .i_we    (w_write),
    .i_waddr (r_tail),
    .i_wdata (w_in_pkt),
    .i_raddr (r_head),
    .o_rdata (w_head_pkt)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios plus a long random run.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, flush, in_en, in_approx, out_reject;
  logic [31:0] in_instr;
  logic [15:0] in_pc;
  logic        in_reject, out_en, out_approx;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic [2:0]  count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_packet_t sbq[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_en      (in_en),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_approx  (in_approx),
    .in_reject  (in_reject),
    .out_en     (out_en),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_approx (out_approx),
    .out_reject (out_reject),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted packets, checked on the negedge.
  always @(negedge clock) begin
    fetch_packet_t exp_pkt;
    logic exp_rej, exp_byp, exp_oen;
    if (reset) begin
      sbq.delete();
    end else begin
      exp_rej = (sbq.size() == DEPTH) || flush;
      exp_byp = BYP && (sbq.size() == 0) && in_en && !out_reject && !flush;
      exp_oen = ((sbq.size() != 0) && !flush) || exp_byp;
      check("mon_count", 64'(count), 64'(sbq.size()));
      check("mon_in_reject", 64'(in_reject), 64'(exp_rej));
      check("mon_out_en", 64'(out_en), 64'(exp_oen));
      if (flush) begin
        sbq.delete();
      end else if (exp_byp) begin
        check("mon_byp_pkt", 64'({out_instr, out_pc, out_approx}),
              64'({in_instr, in_pc, in_approx}));
      end else begin
        if (exp_oen && !out_reject) begin
          exp_pkt = sbq.pop_front();
          check("mon_out_pkt", 64'({out_instr, out_pc, out_approx}), 64'(exp_pkt));
        end
        if (in_en && !exp_rej)
          sbq.push_back('{instr: in_instr, pc: in_pc, approx: in_approx});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] pc, input logic orej, input logic fl);
    in_en      = en;
    in_pc      = pc;
    in_instr   = 32'hA000_0000 + 32'(pc);
    in_approx  = pc[0];
    out_reject = orej;
    flush      = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step();
    @(negedge clock);
    check("rst_in_reject", 64'(in_reject), 64'd1);
    check("rst_out_en", 64'(out_en), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_in_reject", 64'(in_reject), 64'd0);

    // Fill to DEPTH with decode stalled, then offer a fifth packet.
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 16'd4, 1'b1, 1'b0);
    @(negedge clock);
    check("full_count", 64'(count), 64'd4);
    check("full_in_reject", 64'(in_reject), 64'd1);

    // Drain: pcs 0..3 on consecutive cycles, pc 4 never appears.
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      @(negedge clock);
      check("drain_out_en", 64'(out_en), 64'd1);
      check("drain_out_pc", 64'(out_pc), 64'(i));
      step();
    end
    @(negedge clock);
    check("drained_out_en", 64'(out_en), 64'd0);
    check("drained_count", 64'(count), 64'd0);

    // Streaming: 20 packets back to back, wrapping the pointers several times.
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'(16'h100 + i), 1'b0, 1'b0);
      @(negedge clock);
      check("stream_count", 64'(count), (i == 0 || BYP) ? 64'd0 : 64'd1);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step();

    // Flush with three stored packets and a push in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h30 + i), 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 16'h99, 1'b0, 1'b1);
    @(negedge clock);
    check("flush_cyc_in_reject", 64'(in_reject), 64'd1);
    check("flush_cyc_out_en", 64'(out_en), 64'd0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clock);
    check("post_flush_count", 64'(count), 64'd0);
    check("post_flush_out_en", 64'(out_en), 64'd0);
    step();
    drive(1'b1, 16'h40, 1'b0, 1'b0);
    if (BYP) begin
      @(negedge clock);
      check("first_after_flush", 64'(out_pc), 64'h40);
      step();
      drive(1'b0, 16'h0, 1'b0, 1'b0);
    end else begin
      step();
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      @(negedge clock);
      check("first_after_flush", 64'(out_pc), 64'h40);
    end
    step();

`ifdef FETCH_QUEUE_BYPASS_EN
    drive(1'b1, 16'h12, 1'b0, 1'b0);
    @(negedge clock);
    check("byp_out_en", 64'(out_en), 64'd1);
    check("byp_out_pc", 64'(out_pc), 64'h12);
    check("byp_count", 64'(count), 64'd0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step();
`endif

    // Random traffic; the negedge model checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 16'(16'h1000 + i),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    step();
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
